// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default line
// parameters and the baud divider helper used by both directions.
package uart_pkg;

    localparam int DEFAULT_CLK_FREQ  = 25_000_000;
    localparam int DEFAULT_BAUD_RATE = 115_200;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } uart_state_t;

    function automatic int uart_div(input int clk, input int baud);
        return clk / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous pads; resets to RESET_VAL so
// idle-high lines do not produce a spurious edge after reset.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/stop framing into a single-word
// holding register with overrun and framing-error reporting.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = DEFAULT_CLK_FREQ,
    parameter int BAUD_RATE = DEFAULT_BAUD_RATE,
    parameter int BITS      = 8
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            rx,
    input  logic            rx_ack,
    output logic [BITS-1:0] rx_data,
    output logic            rx_valid,
    output logic            rx_overrun,
    output logic            frame_err
);

    localparam int DIV  = uart_div(CLK_FREQ, BAUD_RATE);
    localparam int HALF = DIV / 2;
    localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW   = (BITS > 1) ? $clog2(BITS) : 1;

    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [IW-1:0] LAST    = IW'(BITS - 1);

    uart_state_t     state;
    logic            rx_s;
    logic            rx_d;
    logic            fall;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   idx;
    logic [BITS-1:0] shift;
    logic [BITS-1:0] shift_nx;
    logic            half_hit;
    logic            full_hit;
    logic            accept;

    sync_2ff #(
        .WIDTH    (1),
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk(CLK),
        .rst(RST),
        .d  (rx),
        .q  (rx_s)
    );

    // Line is LSB-first: each new bit enters at the MSB and walks down.
    always_comb begin
        shift_nx = BITS'({rx_s, shift} >> 1);
    end

    assign fall     = rx_d & ~rx_s;
    assign half_hit = (cnt == HALF_M1);
    assign full_hit = (cnt == DIV_M1);
    assign accept   = (state == ST_STOP) && full_hit && rx_s;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            rx_d       <= 1'b1;
            cnt        <= '0;
            idx        <= '0;
            shift      <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_d      <= rx_s;
            frame_err <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (fall) begin
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (half_hit) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state <= ST_DATA;
                            idx   <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (full_hit) begin
                        cnt   <= '0;
                        shift <= shift_nx;
                        if (idx == LAST) begin
                            state <= ST_STOP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (full_hit) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= ST_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= ST_BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_BREAK: begin
                    cnt <= '0;
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase

            // A completing frame takes priority over a same-cycle ack.
            if (accept) begin
                if (!rx_valid || rx_ack) begin
                    rx_data  <= shift;
                    rx_valid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_ack && rx_valid) begin
                rx_valid   <= 1'b0;
                rx_overrun <= 1'b0;
            end
        end
    end

endmodule
